// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx in the echo path.
// First-word-fall-through read side; bytes arriving while full are dropped and flagged.
module uart_byte_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [DATA_W-1:0]        s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [DATA_W-1:0]        m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     afull_o,
  output logic                     overrun_o,
  input  logic                     clr_overrun_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AfullLvl = PW'(AFULL_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overrun_q, overrun_d;

  logic full, empty, push, pop, drop;

  // Wrap-bit encoding: MSB distinguishes full from empty when indices match.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push  = s_valid_i && !full;
    drop  = s_valid_i && full;
    pop   = !empty && m_ready_i;
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // A drop in the same cycle as a clear keeps the flag set.
    overrun_d = drop ? 1'b1 : (clr_overrun_i ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data_i;
    end
  end

  always_comb begin
    s_ready_o = !full;
    m_valid_o = !empty;
    m_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    level_o   = wr_ptr_q - rd_ptr_q;
    afull_o   = (level_o >= AfullLvl);
    overrun_o = overrun_q;
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed self-checking bench for uart_byte_fifo (DEPTH 16, AFULL_LVL 12).
module tb_uart_byte_fifo;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       afull;
  logic       overrun;
  logic       clr_overrun;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  uart_byte_fifo #(
    .DATA_W   (8),
    .DEPTH    (16),
    .AFULL_LVL(12)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .level_o      (level),
    .afull_o      (afull),
    .overrun_o    (overrun),
    .clr_overrun_i(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_valid     = 1'b0;
    s_data      = 8'h00;
    m_ready     = 1'b0;
    clr_overrun = 1'b0;
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    #12;
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_afull", 32'(afull), 0);
    check("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Three writes with the consumer stalled; head must hold.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h41 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    check("t1_level", 32'(level), 3);
    check("t1_valid", 32'(m_valid), 1);
    check("t1_head", 32'(m_data), 32'h41);
    step();
    check("t1_head_hold", 32'(m_data), 32'h41);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_read", 32'(m_data), 32'h41 + 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("t1_empty_valid", 32'(m_valid), 0);
    check("t1_empty_level", 32'(level), 0);

    // Fill to full, then a dropped write together with a clear: drop wins.
    for (int i = 0; i < 16; i++) begin
      check("t2_afull_rise", 32'(afull), (i >= 12) ? 1 : 0);
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
    end
    check("t2_full_level", 32'(level), 16);
    check("t2_full_ready", 32'(s_ready), 0);
    check("t2_full_afull", 32'(afull), 1);
    s_data      = 8'hFF;
    clr_overrun = 1'b1;
    step();
    idle_inputs();
    check("t2_drop_overrun", 32'(overrun), 1);
    check("t2_drop_level", 32'(level), 16);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", 32'(m_data), 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("t2_drained_valid", 32'(m_valid), 0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("t2_clr", 32'(overrun), 0);

    // Streaming push and pop every cycle across several pointer wraps.
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        check("t3_data", 32'(m_data), 32'h80 + 32'(k - 1));
        check("t3_level", 32'(level), 1);
      end
      s_valid = 1'b1;
      s_data  = 8'h80 + 8'(k);
      step();
    end
    s_valid = 1'b0;
    check("t3_last", 32'(m_data), 32'h80 + 39);
    step();
    m_ready = 1'b0;
    check("t3_end_level", 32'(level), 0);
    check("t3_overrun", 32'(overrun), 0);

    // Full with simultaneous write and pop: pop happens, write dropped.
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h20 + 8'(i);
      step();
    end
    s_data  = 8'hEE;
    m_ready = 1'b1;
    step();
    idle_inputs();
    check("t4_level", 32'(level), 15);
    check("t4_overrun", 32'(overrun), 1);
    check("t4_head", 32'(m_data), 32'h21);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("t4_clr", 32'(overrun), 0);
    m_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("t4_drain", 32'(m_data), 32'h20 + 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("t4_empty", 32'(m_valid), 0);

    // Asynchronous reset mid-cycle with five entries stored.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h60 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    check("t5_level", 32'(level), 5);
    #2 arst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(level), 0);
    check("t5_async_valid", 32'(m_valid), 0);
    check("t5_async_ready", 32'(s_ready), 1);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_valid = 1'b0;
    check("t5_post_data", 32'(m_data), 32'h55);
    check("t5_post_level", 32'(level), 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t5_post_empty", 32'(m_valid), 0);
    check("t5_post_level0", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
- Byte FIFO placed between uart_rx and uart_tx in the echo path.
- Absorbs bursts from the receiver while the transmitter is busy serialising.
- uart_rx cannot be stalled, so a byte presented while the FIFO is full is dropped and recorded in a sticky overrun flag.
- Valid/ready handshake on both sides; read side is first-word-fall-through.

Parameters:
- DATA_W, 8, byte width.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- AFULL_LVL, 12, occupancy at or above which afull_o asserts; valid range 1..DEPTH.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- arst_n_i  in  1  reset, asynchronous assert, active-low.
- s_data_i  in  DATA_W  write byte, from uart_rx RxData_o.
- s_valid_i  in  1  write request, from uart_rx valid_o.
- s_ready_o  out  1  FIFO not full, to uart_rx ready_i.
- m_data_o  out  DATA_W  head byte, to uart_tx data_i.
- m_valid_o  out  1  FIFO not empty, to uart_tx valid_i.
- m_ready_i  in  1  consumer accepts head, from uart_tx ready_o.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- afull_o  out  1  level_o >= AFULL_LVL.
- overrun_o  out  1  sticky: at least one byte dropped.
- clr_overrun_i  in  1  synchronous clear of overrun_o.

Behaviour:
- Reset (arst_n_i low, asynchronous): wr_ptr = rd_ptr = 0, level_o = 0, m_valid_o = 0, s_ready_o = 1, afull_o = 0, overrun_o = 0. m_data_o is don't-care. Storage is not cleared.
- Reset mid-transfer discards all contents; the first write after deassertion lands in entry 0.
- Pointers are $clog2(DEPTH)+1 bits with wrap-bit encoding.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
  - Index wraps DEPTH-1 -> 0 naturally.
- Derived outputs: s_ready_o = !full, m_valid_o = !empty, both combinational from registered pointers.
- push = s_valid_i & !full. On push, mem[wr_ptr] <= s_data_i and wr_ptr increments.
- pop = m_valid_o & m_ready_i. On pop, rd_ptr increments.
- m_data_o = mem[rd_ptr], combinational read of the register array (FWFT).
- Latency:
  - A byte written on edge N is visible on m_data_o with m_valid_o = 1 after edge N, i.e. in cycle N+1.
  - A pop on edge N presents the next entry in cycle N+1.
- Simultaneous push and pop when not full and not empty: both occur and level_o is unchanged.
- Push and pop when empty cannot happen, since m_valid_o = 0.
- Write while full (s_valid_i & full):
  - The byte is dropped and no pointer moves.
  - overrun_o <= 1 on that edge, even if a pop occurs in the same cycle. The pop still executes.
- overrun_o clears on an edge where clr_overrun_i = 1 and no new drop occurs. If both happen in the same cycle, the drop wins and overrun_o stays 1.
- level_o = wr_ptr - rd_ptr, modulo 2^(ptr width). Updated registered and consistent with pointers every cycle.
- afull_o is combinational from level_o.
- m_data_o must stay stable while m_valid_o = 1 and m_ready_i = 0. A push to another entry must not alter the head.
- No other states exist. The control is the pointer pair plus the overrun flag register.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 with m_ready_i = 0 -> level_o = 3, m_valid_o = 1, m_data_o = 0x41 held stable. Then raise m_ready_i for 3 cycles -> reads 0x41, 0x42, 0x43 in order, then m_valid_o = 0, level_o = 0.
- Fill 16 bytes 0x00..0x0F -> s_ready_o = 0 at level 16, afull_o = 1 from level 12. A 17th write of 0xFF -> dropped, overrun_o = 1, drain returns 0x00..0x0F only.
- Continuous push and pop every cycle for 40 bytes (pointer wrap 2.5 times) -> output sequence equals input, level_o constant at 1 after the first cycle, overrun_o = 0.
- Full FIFO with s_valid_i = 1 and m_ready_i = 1 in the same cycle -> level_o becomes 15, the write is dropped, overrun_o = 1. Assert clr_overrun_i on a later cycle with no drop -> overrun_o = 0.
- Assert arst_n_i low asynchronously, mid-cycle, with 5 entries stored -> outputs go to reset values immediately, not at the next edge. After release, a write of 0x55 then a pop -> 0x55, level_o = 0.
- Loopback with uart_rx and uart_tx at 115200 baud: receive "HELLO" back-to-back -> TxD_o transmits "HELLO" in order, overrun_o = 0.
